pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter N, default 4, meaning PWM counter width; period = 2^N steps.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning number of independent PWM channels.
REQ-003 SHALL have parameter PRE_W, default 12, meaning prescaler tick-count width.
REQ-004 SHALL have parameter DT_W, default 4, meaning dead-time counter width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port ena, input, 1, meaning global run enable.
REQ-008 SHALL have port ticks, input, PRE_W, meaning clk cycles per PWM step.
REQ-009 SHALL have port duty, input, CHANNELS*(N+1), meaning per-channel duty; channel k in bits [k*(N+1) +: N+1].
REQ-010 SHALL have port load, input, 1, meaning one-cycle strobe that captures duty into the shadow registers.
REQ-011 SHALL have port dead, input, DT_W, meaning dead-time in clk cycles, shared by all channels.
REQ-012 SHALL have port out, output, CHANNELS, meaning high-side PWM outputs.
REQ-013 SHALL have port out_n, output, CHANNELS, meaning complementary low-side outputs.
REQ-014 SHALL have port period_start, output, 1, meaning one-cycle pulse when the PWM counter wraps to 0.

Function
REQ-015 SHALL run a prescaler counting 0..ticks-1 while ena=1 and emit an internal step in the cycle it equals ticks-1, then return to 0; ticks=0 or 1 SHALL step every cycle.
REQ-016 SHALL advance an N-bit counter cnt by 1 on each step; it wraps 2^N-1 -> 0.
REQ-017 SHALL pulse period_start for exactly one clk cycle, registered, in the cycle after cnt wraps to 0.
REQ-018 SHALL capture duty into per-channel shadow registers and set a pending flag on load=1.
REQ-019 SHALL copy shadow to active duty and clear pending on the wrap step, only if pending is set; mid-period duty never changes.
REQ-020 SHALL apply a load coinciding with the wrap step at the following wrap; the old shadow transfers, and the new value stays pending.
REQ-021 SHALL compute raw_k = (cnt < active_k); active_k = 0 gives 0%, and active_k >= 2^N gives 100%, saturating.
REQ-022 SHALL, with dead=0, drive out_k = raw_k and out_n_k = ~raw_k, registered, 1 clk cycle after cnt changes.
REQ-023 SHALL, on any raw_k edge with dead>0, drive out_k and out_n_k low for exactly dead clk cycles, then assert the side matching raw_k.
REQ-024 SHALL restart the dead-time count from dead if raw_k toggles again during it; both outputs stay low.
REQ-025 SHALL never assert out_k and out_n_k in the same cycle, under any input sequence.
REQ-026 SHALL, with ena=0, hold prescaler and cnt, force out and out_n low next cycle, and suppress period_start.
REQ-027 SHALL, on ena 0->1, keep both outputs low for dead cycles before asserting the raw_k-selected side; counting resumes from the held values.
REQ-028 SHALL sample a dead change only at the start of each new dead-time interval.

Reset
REQ-029 SHALL, on rst=0, asynchronously clear prescaler, cnt, shadow, active, pending, and dead-time counters to 0.
REQ-030 SHALL hold out, out_n, and period_start at 0 while rst=0.
REQ-031 SHALL, after rst deassert, hold both outputs low for dead cycles before asserting out_n (raw=0), as on ena rise.
REQ-032 SHALL, on reset mid-period, discard the pending duty and restart from cnt=0 with active duty 0.

Verification
REQ-033 SHALL verify: N=4, ticks=3, dead=0, load duty0=4 -> after the next wrap, out0 high 12 clk of every 48-clk period, out_n0 its exact complement.
REQ-034 SHALL verify: duty0=0 and duty1=16 loaded -> out0 constantly 0, out1 constantly 1 after wrap, with no glitches at wrap.
REQ-035 SHALL verify: dead=2, duty0=8, ticks=3 -> at each raw edge both outputs low exactly 2 clk; out0 high 22 clk per period; out & out_n never both 1.
REQ-036 SHALL verify: load duty0=10 at cnt=5 -> current period keeps old duty; new duty visible from the first step after period_start.
REQ-037 SHALL verify: ena=0 for 20 clk mid-period -> outputs 0 next cycle, cnt frozen; on re-enable, both low for dead cycles, then counting resumes from the frozen cnt.
REQ-038 SHALL verify: rst asserted mid-period with load pending -> outputs 0 immediately; after release, active duty is 0 and out stays 0 until a new load and wrap.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared prescaler,
// double-buffered duty registers and per-channel complementary outputs
// with dead-time insertion.
//
// Ports:
//   clk          - clock, all logic on its rising edge
//   rst          - asynchronous active-low reset
//   ena          - global run enable; low freezes counting and forces outputs low
//   ticks        - clk cycles per PWM step (0 or 1 steps every cycle)
//   duty         - per-channel duty, channel k in [k*(N+1) +: N+1]
//   load         - one-cycle strobe capturing duty into the shadow registers
//   dead         - dead-time in clk cycles, shared by all channels
//   out          - high-side PWM outputs
//   out_n        - complementary low-side outputs
//   period_start - one-cycle pulse in the first cycle with cnt = 0
module pwm_multi #(
  parameter int N        = 4,
  parameter int CHANNELS = 2,
  parameter int PRE_W    = 12,
  parameter int DT_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [PRE_W-1:0]             ticks,
  input  logic [CHANNELS*(N+1)-1:0]    duty,
  input  logic                         load,
  input  logic [DT_W-1:0]              dead,
  output logic [CHANNELS-1:0]          out,
  output logic [CHANNELS-1:0]          out_n,
  output logic                         period_start
);

  logic [PRE_W-1:0]             r_pre;
  logic [N-1:0]                 r_cnt;
  logic                         r_ps;
  logic [CHANNELS-1:0][N:0]     r_shadow;
  logic [CHANNELS-1:0][N:0]     r_active;
  logic                         r_pending;
  logic [CHANNELS-1:0][DT_W-1:0] r_dt;
  logic [CHANNELS-1:0]          r_raw_q;
  logic                         r_arm;
  logic [CHANNELS-1:0]          r_out;
  logic [CHANNELS-1:0]          r_outn;

  logic                         w_pre_last;
  logic                         w_step;
  logic                         w_wrap;
  logic [CHANNELS-1:0]          w_raw;

  // >= rather than == so a prescaler left above a newly lowered ticks
  // value steps immediately instead of running round the full range.
  assign w_pre_last = (ticks <= PRE_W'(1)) || (r_pre >= ticks - PRE_W'(1));
  assign w_step     = ena && w_pre_last;
  assign w_wrap     = w_step && (r_cnt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_ps  <= 1'b0;
    end else begin
      if (ena) begin
        r_pre <= w_pre_last ? '0 : r_pre + PRE_W'(1);
      end
      if (w_step) begin
        r_cnt <= r_cnt + N'(1);
      end
      r_ps <= w_wrap;
    end
  end

  // A load on the wrap step transfers the previous shadow value while the
  // new value is captured and stays pending for the following wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_active <= r_shadow;
      end
      if (load) begin
        r_shadow <= duty;
      end
      r_pending <= load || (r_pending && !w_wrap);
    end
  end

  // Duty values at or above 2^N exceed every cnt value and saturate to 100%.
  always_comb begin
    w_raw = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_raw[k] = ({1'b0, r_cnt} < r_active[k]);
    end
  end

  // r_dt holds the remaining low cycles of a dead-time interval; r_arm
  // requests a fresh interval after reset or while ena is low, so outputs
  // come up through dead-time exactly as they do on a raw edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dt    <= '0;
      r_raw_q <= '0;
      r_arm   <= 1'b1;
      r_out   <= '0;
      r_outn  <= '0;
    end else begin
      r_raw_q <= w_raw;
      if (!ena) begin
        r_arm  <= 1'b1;
        r_dt   <= '0;
        r_out  <= '0;
        r_outn <= '0;
      end else begin
        r_arm <= 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          if (r_arm || (w_raw[k] != r_raw_q[k])) begin
            if (dead == '0) begin
              r_dt[k]   <= '0;
              r_out[k]  <= w_raw[k];
              r_outn[k] <= !w_raw[k];
            end else begin
              r_dt[k]   <= dead;
              r_out[k]  <= 1'b0;
              r_outn[k] <= 1'b0;
            end
          end else if (r_dt[k] > DT_W'(1)) begin
            r_dt[k]   <= r_dt[k] - DT_W'(1);
            r_out[k]  <= 1'b0;
            r_outn[k] <= 1'b0;
          end else begin
            r_dt[k]   <= '0;
            r_out[k]  <= w_raw[k];
            r_outn[k] <= !w_raw[k];
          end
        end
      end
    end
  end

  assign out          = r_out;
  assign out_n        = r_outn;
  assign period_start = r_ps;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi with default
// parameters (N=4, 2 channels). Expected values are hand-computed counts
// of output-high cycles per period and exact cycle offsets.
module tb_pwm_multi;

  localparam int N     = 4;
  localparam int CH    = 2;
  localparam int PRE_W = 12;
  localparam int DT_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ena;
  logic [PRE_W-1:0]      ticks;
  logic [CH*(N+1)-1:0]   duty;
  logic                  load;
  logic [DT_W-1:0]       dead;
  logic [CH-1:0]         out;
  logic [CH-1:0]         out_n;
  logic                  period_start;

  int tests   = 0;
  int fails   = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  pwm_multi #(.N(N), .CHANNELS(CH), .PRE_W(PRE_W), .DT_W(DT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ticks(ticks), .duty(duty),
    .load(load), .dead(dead), .out(out), .out_n(out_n),
    .period_start(period_start)
  );

  always @(negedge clk) begin
    if ((out & out_n) != '0) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic set_duty(input int d0, input int d1);
    duty[0 +: N+1]     = (N+1)'(d0);
    duty[N+1 +: N+1]   = (N+1)'(d1);
  endtask

  task automatic do_load(input int d0, input int d1);
    set_duty(d0, d1);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ps();
    logic seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = period_start;
      n++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_ps: period_start=%0b after %0d clk, required 1", period_start, n);
    end
  endtask

  task automatic measure(input int n, output int h0, output int hn0, output int h1,
                         output int hn1, output int lo0, output int cmp0,
                         output int psc, output logic ps_last);
    h0 = 0; hn0 = 0; h1 = 0; hn1 = 0; lo0 = 0; cmp0 = 0; psc = 0; ps_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h0   += int'(out[0]);
      hn0  += int'(out_n[0]);
      h1   += int'(out[1]);
      hn1  += int'(out_n[1]);
      lo0  += int'(!out[0] && !out_n[0]);
      cmp0 += int'(out_n[0] == out[0]);
      psc  += int'(period_start);
      ps_last = period_start;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1; load = 1'b0; ticks = PRE_W'(3); dead = '0;
    set_duty(0, 0);
    repeat (3) @(negedge clk);
    tests++; if (out !== 2'b00) begin fails++; $display("FAIL reset_out: got %b, want 00", out); end
    tests++; if (out_n !== 2'b00) begin fails++; $display("FAIL reset_out_n: got %b, want 00", out_n); end
    tests++; if (period_start !== 1'b0) begin fails++; $display("FAIL reset_ps: got %b, want 0", period_start); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (out_n !== 2'b11) begin fails++; $display("FAIL release_out_n: got %b, want 11", out_n); end
    tests++; if (out !== 2'b00) begin fails++; $display("FAIL release_out: got %b, want 00", out); end
  endtask

  task automatic test_duty_basic();
    int h0, hn0, h1, hn1, lo0, cmp0, psc; logic psl;
    wait_ps();
    do_load(4, 0);
    wait_ps();
    measure(48, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 12) begin fails++; $display("FAIL basic_out0_high: got %0d, want 12", h0); end
    tests++; if (cmp0 !== 0) begin fails++; $display("FAIL basic_complement: got %0d non-complement cycles, want 0", cmp0); end
    tests++; if (psl !== 1'b1 || psc !== 1) begin fails++; $display("FAIL basic_period: ps_last=%0b count=%0d, want 1/1", psl, psc); end
    measure(48, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 12) begin fails++; $display("FAIL basic_out0_high2: got %0d, want 12", h0); end
    tests++; if (h1 !== 0 || hn1 !== 48) begin fails++; $display("FAIL basic_ch1: out1=%0d out_n1=%0d, want 0/48", h1, hn1); end
  endtask

  task automatic test_extremes();
    int h0, hn0, h1, hn1, lo0, cmp0, psc; logic psl;
    wait_ps();
    do_load(0, 16);
    wait_ps();
    measure(96, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 0 || hn0 !== 96) begin fails++; $display("FAIL extreme_ch0: out0=%0d out_n0=%0d, want 0/96", h0, hn0); end
    tests++; if (h1 !== 96 || hn1 !== 0) begin fails++; $display("FAIL extreme_ch1: out1=%0d out_n1=%0d, want 96/0", h1, hn1); end
  endtask

  task automatic test_deadtime();
    int h0, hn0, h1, hn1, lo0, cmp0, psc; logic psl;
    wait_ps();
    dead = DT_W'(2);
    do_load(8, 20);
    wait_ps();
    measure(48, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 22 || hn0 !== 22) begin fails++; $display("FAIL dead_high: out0=%0d out_n0=%0d, want 22/22", h0, hn0); end
    tests++; if (lo0 !== 4) begin fails++; $display("FAIL dead_low: got %0d both-low cycles, want 4", lo0); end
    tests++; if (h1 !== 48) begin fails++; $display("FAIL dead_ch1_sat: got %0d, want 48", h1); end
    measure(48, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 22 || lo0 !== 4) begin fails++; $display("FAIL dead_period2: out0=%0d low=%0d, want 22/4", h0, lo0); end
  endtask

  task automatic test_load_midperiod();
    int h0, hn0, o29;
    wait_ps();
    h0 = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      h0 += int'(out[0]);
      if (i == 15) begin set_duty(10, 20); load = 1'b1; end
      if (i == 16) load = 1'b0;
      if (i == 48) begin
        tests++; if (period_start !== 1'b1) begin fails++; $display("FAIL mid_ps: got %b, want 1", period_start); end
      end
    end
    tests++; if (h0 !== 22) begin fails++; $display("FAIL mid_old_duty: got %0d, want 22", h0); end
    h0 = 0; hn0 = 0; o29 = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      h0  += int'(out[0]);
      hn0 += int'(out_n[0]);
      if (i == 29) o29 = int'(out[0]);
    end
    tests++; if (h0 !== 28 || hn0 !== 16) begin fails++; $display("FAIL mid_new_duty: out0=%0d out_n0=%0d, want 28/16", h0, hn0); end
    tests++; if (o29 !== 1) begin fails++; $display("FAIL mid_new_visible: out0 at step 9 = %0d, want 1", o29); end
  endtask

  task automatic test_ena_pause();
    int nz, psc, first;
    logic [CH-1:0] a, b, c_o, c_n;
    wait_ps();
    repeat (16) @(negedge clk);
    tests++; if (out !== 2'b11) begin fails++; $display("FAIL pause_pre: got %b, want 11", out); end
    ena = 1'b0;
    nz = 0; psc = 0;
    for (int i = 17; i <= 36; i++) begin
      @(negedge clk);
      nz  += int'((out | out_n) != '0);
      psc += int'(period_start);
    end
    ena = 1'b1;
    tests++; if (nz !== 0 || psc !== 0) begin fails++; $display("FAIL pause_hold: active=%0d ps=%0d, want 0/0", nz, psc); end
    @(negedge clk); a = out | out_n;
    @(negedge clk); b = out | out_n;
    @(negedge clk); c_o = out; c_n = out_n;
    tests++; if ((a | b) !== 2'b00) begin fails++; $display("FAIL pause_dead: got %b/%b, want 00/00", a, b); end
    tests++; if (c_o !== 2'b11 || c_n !== 2'b00) begin fails++; $display("FAIL pause_resume: out=%b out_n=%b, want 11/00", c_o, c_n); end
    first = -1;
    for (int i = 40; i < 240 && first < 0; i++) begin
      @(negedge clk);
      if (period_start) first = i;
    end
    tests++; if (first !== 68) begin fails++; $display("FAIL pause_cnt_frozen: period_start at %0d, want 68", first); end
  endtask

  task automatic test_back_to_back();
    int h0, hn0, h1, hn1, lo0, cmp0, psc; logic psl;
    wait_ps();
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      if (i == 5) begin set_duty(12, 20); load = 1'b1; end
      if (i == 6) load = 1'b0;
      if (i == 47) begin set_duty(2, 20); load = 1'b1; end
      if (i == 48) begin
        load = 1'b0;
        tests++; if (period_start !== 1'b1) begin fails++; $display("FAIL b2b_ps: got %b, want 1", period_start); end
      end
    end
    measure(48, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 34) begin fails++; $display("FAIL b2b_old_shadow: got %0d, want 34", h0); end
    measure(48, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 4 || hn0 !== 40) begin fails++; $display("FAIL b2b_deferred: out0=%0d out_n0=%0d, want 4/40", h0, hn0); end
  endtask

  task automatic test_retrigger();
    int h0, hn0, h1, hn1, lo0, cmp0, psc; logic psl;
    wait_ps();
    ticks = PRE_W'(1);
    dead  = DT_W'(4);
    do_load(1, 15);
    wait_ps();
    repeat (16) @(negedge clk);
    measure(16, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 0 || hn0 !== 11) begin fails++; $display("FAIL retrig_ch0: out0=%0d out_n0=%0d, want 0/11", h0, hn0); end
    tests++; if (h1 !== 11 || hn1 !== 0) begin fails++; $display("FAIL retrig_ch1: out1=%0d out_n1=%0d, want 11/0", h1, hn1); end
    tests++; if (psc !== 1) begin fails++; $display("FAIL ticks1_period: got %0d pulses in 16 clk, want 1", psc); end
    ticks = '0;
    repeat (16) @(negedge clk);
    measure(16, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (psc !== 1 || hn0 !== 11) begin fails++; $display("FAIL ticks0_period: ps=%0d out_n0=%0d, want 1/11", psc, hn0); end
  endtask

  task automatic test_reset_mid();
    int h0, hn0, h1, hn1, lo0, cmp0, psc; logic psl;
    int nz, first, hi;
    logic [CH-1:0] o3, n3;
    ticks = PRE_W'(3);
    dead  = DT_W'(2);
    wait_ps();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) begin set_duty(6, 0); load = 1'b1; end
      if (i == 11) load = 1'b0;
    end
    rst = 1'b0;
    #1;
    tests++; if (out !== 2'b00 || out_n !== 2'b00 || period_start !== 1'b0) begin
      fails++; $display("FAIL rst_async: out=%b out_n=%b ps=%b, want 00/00/0", out, out_n, period_start);
    end
    nz = 0;
    repeat (3) begin
      @(negedge clk);
      nz += int'(((out | out_n) != '0) || period_start);
    end
    tests++; if (nz !== 0) begin fails++; $display("FAIL rst_hold: got %0d active cycles, want 0", nz); end
    rst = 1'b1;
    nz = 0;
    repeat (2) begin
      @(negedge clk);
      nz += int'((out | out_n) != '0);
    end
    @(negedge clk); o3 = out; n3 = out_n;
    tests++; if (nz !== 0) begin fails++; $display("FAIL rst_dead: got %0d active cycles, want 0", nz); end
    tests++; if (o3 !== 2'b00 || n3 !== 2'b11) begin fails++; $display("FAIL rst_out_n: out=%b out_n=%b, want 00/11", o3, n3); end
    first = -1; hi = 0;
    for (int i = 4; i <= 108; i++) begin
      @(negedge clk);
      if (period_start && first < 0) first = i;
      hi += int'(out[0]);
    end
    tests++; if (first !== 48) begin fails++; $display("FAIL rst_cnt_restart: period_start at %0d, want 48", first); end
    tests++; if (hi !== 0) begin fails++; $display("FAIL rst_pending_discard: out0 high %0d cycles, want 0", hi); end
    do_load(6, 0);
    wait_ps();
    measure(48, h0, hn0, h1, hn1, lo0, cmp0, psc, psl);
    tests++; if (h0 !== 16) begin fails++; $display("FAIL rst_new_load: got %0d, want 16", h0); end
  endtask

  task automatic test_exclusive();
    tests++;
    if (overlap !== 0) begin fails++; $display("FAIL exclusive: out & out_n both high in %0d cycles, want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_duty_basic();
    test_extremes();
    test_deadtime();
    test_load_midperiod();
    test_ena_pause();
    test_back_to_back();
    test_retrigger();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
